seg7_frame_capture: RTL



---
 rtl/seg7_frame_capture.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seg7_frame_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus.
// Each strobe dwell is qualified, decoded once, assembled into a frame, and handed off over valid/ready.
module seg7_frame_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  // Current and previous registered samples of the display pins.
  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   dig_q, dig_p;

  logic [1:0]              state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0]   seen, seen_nxt;
  logic [4*NUM_DIGITS-1:0] work_data;
  logic [NUM_DIGITS-1:0]   work_err;

  logic [NUM_DIGITS-1:0]   sel_low;
  logic                    sample_valid;
  logic                    changed;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   cap_mask;
  logic [4:0]              decoded;
  logic                    xfer;

  // Returns {err, nibble}; undecodable patterns report nibble F with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      default:    decode = 5'h1F;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves a latch behind.
    state_nxt    = state;
    cnt_nxt      = cnt;
    capture      = 1'b0;
    sel_low      = ~dig_q;
    sample_valid = $onehot(sel_low);
    changed      = (seg_q != seg_p) || (dig_q != dig_p);

    if (!sample_valid) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 4'd0;
    end else if (state == ST_IDLE || changed) begin
      state_nxt = ST_SETTLE;
      cnt_nxt   = 4'd1;
    end else if (state == ST_SETTLE) begin
      cnt_nxt   = cnt + 4'd1;
    end

    // The capture fires on the edge where the count reaches its target, then the dwell is held.
    if (sample_valid && state_nxt == ST_SETTLE && cnt_nxt == STABLE_CNT) begin
      capture   = 1'b1;
      state_nxt = ST_HELD;
    end

    cap_mask = capture ? sel_low : '0;
    decoded  = decode(seg_q);
    xfer     = (&seen) && (!frame_valid || frame_ready);
    // A capture coinciding with a transfer belongs to the next frame.
    seen_nxt = (xfer ? '0 : seen) | cap_mask;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      seg_p <= '0;
      dig_q <= '0;
      dig_p <= '0;
      state <= ST_IDLE;
      cnt   <= '0;
      seen  <= '0;
    end else begin
      seg_q <= seg_n;
      seg_p <= seg_q;
      dig_q <= dig_sel_n;
      dig_p <= dig_q;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      seen  <= seen_nxt;
    end
  end

  // The working bank is small and cleared on reset so a partial frame never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_data <= '0;
      work_err  <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          work_data[4*i +: 4] <= decoded[3:0];
          work_err[i]         <= decoded[4];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
    end else if (xfer) begin
      frame_data  <= work_data;
      frame_err   <= work_err;
      frame_valid <= 1'b1;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule
